fmdll_div_counter: RTL and testbench
====================================

FMDLL_DIV_COUNTER -- requirements
Module: fmdll_div_counter

Interface
REQ-001 SHALL have port clk_out, input, 1 bit: the DLL output clock and the only clock.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous to clk_out and active-low.
REQ-003 SHALL have port en, input, 1 bit: count enable.
REQ-004 SHALL have port N, input, 4 bits: multiplication factor, sampled only into a shadow register.
REQ-005 SHALL have port M, input, 2 bits: frame count per reference period, sampled only into a shadow register.
REQ-006 SHALL have port clk_ext, input, 1 bit: reference clock, asynchronous, used only through the synchronizer.
REQ-007 SHALL have port N_counter, output, 4 bits: position within the N-frame, range 1..N_eff.
REQ-008 SHALL have port M_counter, output, 2 bits: index of the N-frame, range 1..M_eff.
REQ-009 SHALL have port DIV_N, output, 1 bit: clk_out divided by N.
REQ-010 SHALL have port DIV_M, output, 1 bit: marker for the reference-period phase.
REQ-011 SHALL have port locked, output, 1 bit: alignment achieved.
REQ-012 SHALL have port phase_err, output, 1 bit: one-cycle pulse on each forced realignment.

Function
REQ-013 SHALL define N_eff as the shadow N clamped to a minimum of 2, so N=0 or N=1 is treated as 2.
REQ-014 SHALL define M_eff as the shadow M clamped to a minimum of 1, so M=0 is treated as 1.
REQ-015 SHALL load the shadows at reset and on every frame wrap, i.e. on each transition to (N_counter,M_counter)=(1,1), including a forced wrap; no N/M change SHALL take effect mid-frame.
REQ-016 SHALL, while en=1, increment N_counter each cycle, and when N_counter=N_eff SHALL wrap it to 1 and advance M_counter.
REQ-017 SHALL wrap M_counter from M_eff to 1.
REQ-018 SHALL hold N_counter and M_counter while en=0.
REQ-019 SHALL compute DIV_N = (N_counter <= (N_eff+1)>>1), so DIV_N=0 whenever N_counter=N_eff.
REQ-020 SHALL compute DIV_M as follows: when M_eff>=2, DIV_M = (M_counter==1); when M_eff==1, DIV_M = DIV_N.
REQ-021 SHALL decode DIV_N and DIV_M only from registered state, with no combinational path from any input to any output.
REQ-022 SHALL pass clk_ext through a 2-flop synchronizer and a rising-edge detector, producing ext_rise as a single-cycle pulse with 2–3 cycles of latency.
REQ-023 SHALL treat ext_rise as aligned when it occurs with N_counter=N_eff and M_counter=M_eff.
REQ-024 SHALL handle an aligned edge by incrementing a saturating alignment counter (saturation value 4) with a normal wrap.
REQ-025 SHALL handle a misaligned ext_rise while en=1 by forcing the next state to (1,1), reloading the shadows, pulsing phase_err for exactly 1 cycle, clearing the alignment counter, and clearing locked the next cycle.
REQ-026 SHALL assert locked in the cycle after the alignment counter reaches 4, and keep it asserted until a misaligned edge, en=0 or reset.
REQ-027 SHALL keep the synchronizer running while en=0, ignore ext_rise while en=0, and clear locked and the alignment counter while en=0.
REQ-028 SHALL, if ext_rise coincides with a natural wrap, treat it as aligned (per REQ-023) with no phase_err.

Reset
REQ-029 SHALL, in a cycle with rst_n=0 at the clk_out edge, set N_counter=1, M_counter=1, locked=0, phase_err=0, alignment counter=0 and synchronizer flops=0, and SHALL load the shadows from N/M; DIV_N and DIV_M therefore read 1.
REQ-030 SHALL give reset priority over en and ext_rise, and a reset asserted mid-frame SHALL take effect at the next clock edge.

Structure
REQ-031 SHALL keep in package fmdll_pkg: N_W=4, M_W=2, N_MIN=2, M_MIN=1, LOCK_CNT=4, and the 2-bit state width shared with the select logic.
REQ-032 SHALL implement the synchronizer and edge detect as sub-module fmdll_sync2 (ports clk_out, rst_n, d_async, rise).
REQ-033 SHALL keep counters, shadows and lock logic in the top module.

Verification
REQ-034 SHALL test: N=4, M=2, en=1, no clk_ext -> N_counter 1,2,3,4,1..., DIV_N 1,1,0,0, M_counter 1 for 4 cycles then 2 for 4 cycles, DIV_M=1 only while M_counter=1.
REQ-035 SHALL test: N=1, M=0 -> behaves as N=2, M=1 (N_counter 1,2,1; DIV_N 1,0; DIV_M=DIV_N).
REQ-036 SHALL test: N=4, M=2, clk_ext rises every 8 cycles with ext_rise landing at (4,2) -> no phase_err, locked=1 the cycle after the 4th aligned edge.
REQ-037 SHALL test: while locked, an ext_rise at N_counter=2 -> next cycle (1,1), phase_err for 1 cycle, locked=0, then relock after 4 further aligned edges.
REQ-038 SHALL test: N changed 4->6 at N_counter=2 -> count reaches 4 then wraps, and the next frame counts to 6.
REQ-039 SHALL test: rst_n=0 for 1 cycle at (3,2) while locked -> (1,1), locked=0, phase_err=0; and en=0 for 5 cycles -> counters frozen, locked=0.

Source files
------------

// File: rtl/fmdll_pkg.sv
// Shared widths, constants and counter-select encoding for the FMDLL divider.
// The clamp helpers define the effective N/M seen by the counters.
package fmdll_pkg;

  localparam int N_W     = 4;
  localparam int M_W     = 2;
  localparam int STATE_W = 2;
  localparam int ALIGN_W = 3;

  localparam logic [N_W-1:0]     N_MIN    = 4'd2;
  localparam logic [M_W-1:0]     M_MIN    = 2'd1;
  localparam logic [ALIGN_W-1:0] LOCK_CNT = 3'd4;

  // What the counters do on the next clock edge.
  typedef enum logic [STATE_W-1:0] {
    SEL_HOLD  = 2'd0,
    SEL_STEP  = 2'd1,
    SEL_WRAP  = 2'd2,
    SEL_FORCE = 2'd3
  } sel_e;

  function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] v);
    return (v < N_MIN) ? N_MIN : v;
  endfunction

  function automatic logic [M_W-1:0] clamp_m(input logic [M_W-1:0] v);
    return (v < M_MIN) ? M_MIN : v;
  endfunction

endpackage

// File: rtl/fmdll_sync2.sv
// Two-flop synchronizer for the reference clock plus a rising-edge detector.
// rise is a one-cycle pulse decoded from flopped history only.
module fmdll_sync2 (
  input  logic clk_out,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  // sr[0], sr[1]: metastability chain; sr[2]: previous synchronized value.
  logic [2:0] sr;

  always_ff @(posedge clk_out) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge value,
    // which is what makes this a shift chain rather than a single wire.
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], d_async};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/fmdll_div_counter.sv
// Frame counter for the FMDLL: N-cycle sub-frames, M sub-frames per reference
// period, divided-clock decodes and reference-edge alignment/lock tracking.
module fmdll_div_counter
  import fmdll_pkg::*;
(
  input  logic           clk_out,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N_W-1:0] N,
  input  logic [M_W-1:0] M,
  input  logic           clk_ext,
  output logic [N_W-1:0] N_counter,
  output logic [M_W-1:0] M_counter,
  output logic           DIV_N,
  output logic           DIV_M,
  output logic           locked,
  output logic           phase_err
);

  logic [N_W-1:0]     n_cnt, n_sh, n_eff;
  logic [M_W-1:0]     m_cnt, m_sh, m_eff;
  logic [N_W:0]       n_half;
  logic [ALIGN_W-1:0] align_cnt;
  logic               lock_q, perr_q, ext_rise, n_end, at_end;
  sel_e               sel;

  fmdll_sync2 u_sync (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .d_async (clk_ext),
    .rise    (ext_rise)
  );

  assign n_eff  = clamp_n(n_sh);
  assign m_eff  = clamp_m(m_sh);
  assign n_end  = (n_cnt == n_eff);
  assign at_end = n_end && (m_cnt == m_eff);

  // An edge at the last cycle of the frame is aligned; anywhere else it forces a restart.
  always_comb begin
    sel = SEL_HOLD;
    if (en) begin
      if (ext_rise && !at_end) sel = SEL_FORCE;
      else if (at_end)         sel = SEL_WRAP;
      else                     sel = SEL_STEP;
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      // NOTE: the shadows reset to the live N/M ports, not to constants, so the
      // first frame after reset already uses the requested ratio.
      n_cnt     <= N_W'(1);
      m_cnt     <= M_W'(1);
      n_sh      <= N;
      m_sh      <= M;
      align_cnt <= '0;
      lock_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      perr_q <= (sel == SEL_FORCE);
      unique case (sel)
        SEL_HOLD: begin
          align_cnt <= '0;
          lock_q    <= 1'b0;
        end
        SEL_STEP: begin
          if (n_end) begin
            n_cnt <= N_W'(1);
            m_cnt <= m_cnt + 1'b1;
          end else begin
            n_cnt <= n_cnt + 1'b1;
          end
        end
        SEL_WRAP: begin
          n_cnt <= N_W'(1);
          m_cnt <= M_W'(1);
          n_sh  <= N;
          m_sh  <= M;
          if (ext_rise) begin
            if (align_cnt != LOCK_CNT)           align_cnt <= align_cnt + 1'b1;
            if (align_cnt >= LOCK_CNT - 1'b1)    lock_q    <= 1'b1;
          end
        end
        SEL_FORCE: begin
          n_cnt     <= N_W'(1);
          m_cnt     <= M_W'(1);
          n_sh      <= N;
          m_sh      <= M;
          align_cnt <= '0;
          lock_q    <= 1'b0;
        end
      endcase
    end
  end

  // Divided outputs decode registered state only.
  assign n_half    = ({1'b0, n_eff} + 1'b1) >> 1;
  assign DIV_N     = ({1'b0, n_cnt} <= n_half);
  assign DIV_M     = (m_eff > M_MIN) ? (m_cnt == M_MIN) : DIV_N;
  assign N_counter = n_cnt;
  assign M_counter = m_cnt;
  assign locked    = lock_q;
  assign phase_err = perr_q;

endmodule

// File: tb/tb_fmdll_div_counter.sv
// Directed self-checking bench for fmdll_div_counter: counting, clamping,
// lock/realign, mid-frame ratio change, reset priority and enable freeze.
module tb_fmdll_div_counter;

  logic       clk_out = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       clk_ext = 1'b0;
  logic [3:0] N       = 4'd4;
  logic [1:0] M       = 2'd2;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N, DIV_M, locked, phase_err;

  int tests  = 0;
  int errors = 0;

  always #5 clk_out = ~clk_out;

  fmdll_div_counter dut (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .en        (en),
    .N         (N),
    .M         (M),
    .clk_ext   (clk_ext),
    .N_counter (N_counter),
    .M_counter (M_counter),
    .DIV_N     (DIV_N),
    .DIV_M     (DIV_M),
    .locked    (locked),
    .phase_err (phase_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {N_counter, M_counter, DIV_N, DIV_M, locked, phase_err};
  endfunction

  // Expected {N_counter, M_counter, DIV_N, DIV_M, locked, phase_err} at cycle
  // 'pos' of a frame with effective ratios neff/meff.
  function automatic logic [9:0] expv(int pos, int neff, int meff, bit lk, bit pe);
    int   n, m;
    logic dn, dm;
    n  = pos % neff + 1;
    m  = (pos / neff) % meff + 1;
    dn = (n <= (neff + 1) / 2);
    dm = (meff >= 2) ? (m == 1) : dn;
    return {4'(n), 2'(m), dn, dm, lk, pe};
  endfunction

  task automatic do_reset(input logic [3:0] n, input logic [1:0] m);
    rst_n   = 1'b0;
    en      = 1'b1;
    clk_ext = 1'b0;
    N       = n;
    M       = m;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Four aligned reference edges from reset; leaves the DUT locked at frame start.
  task automatic lock_up();
    do_reset(4'd4, 2'd2);
    for (int c = 0; c < 32; c++) begin
      clk_ext = (c % 8 >= 5);
      tick();
    end
    clk_ext = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0; en = 1'b1; clk_ext = 1'b0; N = 4'd4; M = 2'd2;
    tick();
    tick();
    e = expv(0, 4, 2, 0, 0);
    tests++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state got {N,M,DN,DM,LK,PE}=%b want %b", obs(), e);
    end
  endtask

  task automatic test_count();
    logic [9:0] e;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      e = expv(k % 8, 4, 2, 0, 0);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL count k=%0d got {N,M,DN,DM,LK,PE}=%b want %b", k, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_clamp();
    logic [9:0] e;
    do_reset(4'd1, 2'd0);
    for (int k = 0; k < 6; k++) begin
      e = expv(k % 2, 2, 1, 0, 0);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL clamp k=%0d got {N,M,DN,DM,LK,PE}=%b want %b", k, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [9:0] e;
    do_reset(4'd4, 2'd2);
    for (int c = 0; c < 40; c++) begin
      e = expv(c % 8, 4, 2, c >= 32, 0);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock c=%0d got {N,M,DN,DM,LK,PE}=%b want %b", c, obs(), e);
      end
      clk_ext = (c % 8 >= 5);
      tick();
    end
  endtask

  // Continues from test_lock: misaligned edge at (2,2), then relock.
  task automatic test_realign();
    logic [9:0] e;
    int         pos;
    for (int t = 0; t < 42; t++) begin
      pos = (t < 6) ? t : (t - 6) % 8;
      e   = expv(pos, 4, 2, (t < 6) || (t >= 38), t == 6);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL realign t=%0d got {N,M,DN,DM,LK,PE}=%b want %b", t, obs(), e);
      end
      clk_ext = (t < 6) ? (t >= 3) : ((t - 6) % 8 >= 5);
      tick();
    end
    clk_ext = 1'b0;
  endtask

  task automatic test_n_change();
    logic [9:0] e;
    do_reset(4'd4, 2'd2);
    for (int k = 0; k < 22; k++) begin
      e = (k < 8) ? expv(k, 4, 2, 0, 0) : expv(k - 8, 6, 2, 0, 0);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL n_change k=%0d got {N,M,DN,DM,LK,PE}=%b want %b", k, obs(), e);
      end
      if (k == 1) N = 4'd6;
      tick();
    end
    N = 4'd4;
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    lock_up();
    repeat (6) tick();
    e = expv(6, 4, 2, 1, 0);
    tests++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_mid_pre got {N,M,DN,DM,LK,PE}=%b want %b", obs(), e);
    end
    rst_n = 1'b0;
    tick();
    e = expv(0, 4, 2, 0, 0);
    tests++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_mid_post got {N,M,DN,DM,LK,PE}=%b want %b", obs(), e);
    end
    rst_n = 1'b1;
    tick();
    e = expv(1, 4, 2, 0, 0);
    tests++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_mid_run got {N,M,DN,DM,LK,PE}=%b want %b", obs(), e);
    end
  endtask

  task automatic test_enable();
    logic [9:0] e;
    lock_up();
    tick();
    tick();
    e = expv(2, 4, 2, 1, 0);
    tests++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL enable_pre got {N,M,DN,DM,LK,PE}=%b want %b", obs(), e);
    end
    en      = 1'b0;
    clk_ext = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = expv(2, 4, 2, 0, 0);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL enable_freeze i=%0d got {N,M,DN,DM,LK,PE}=%b want %b", i, obs(), e);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = expv(3 + i, 4, 2, 0, 0);
      tests++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL enable_resume i=%0d got {N,M,DN,DM,LK,PE}=%b want %b", i, obs(), e);
      end
    end
    clk_ext = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_clamp();
    test_lock();
    test_realign();
    test_n_change();
    test_reset_mid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
